// File: rtl/row_arb_pkg.sv
// Shared definitions for the row packet arbiter: FSM encoding, header layout, word width.
package row_arb_pkg;

    localparam int PKT_W        = 16;
    localparam int HDR_BLEN_MSB = 15;
    localparam int HDR_ROW_MSB  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BURST = 2'd2
    } state_t;

endpackage

// File: rtl/row_packet_arbiter_if.sv
// Encoder-side and link-side signals of the row packet arbiter.
interface row_packet_arbiter_if #(parameter int N_ROWS = 4);
    import row_arb_pkg::*;

    logic [PKT_W*N_ROWS-1:0] enc_data;
    logic [N_ROWS-1:0]       enc_ready;
    logic [PKT_W-1:0]        out_data;
    logic                    out_hdr;
    logic                    out_valid;
    logic                    out_ready;
    logic [N_ROWS-1:0]       ovf_flag;
    logic                    ovf_clear;

    modport master (
        input  enc_data, enc_ready, out_ready, ovf_clear,
        output out_data, out_hdr, out_valid, ovf_flag
    );

    modport slave (
        output enc_data, enc_ready, out_ready, ovf_clear,
        input  out_data, out_hdr, out_valid, ovf_flag
    );

endinterface

// File: rtl/row_pkt_fifo.sv
// Per-row synchronous FIFO; head word is read combinationally from storage.
module row_pkt_fifo #(
    parameter  int DEPTH = 8,
    parameter  int W     = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/row_packet_arbiter.sv
// Round-robin merge of per-row encoder streams onto one link as header-prefixed bursts.
module row_packet_arbiter
    import row_arb_pkg::*;
#(
    parameter int N_ROWS     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               rst,
    row_packet_arbiter_if.master bus
);

    localparam int GW = $clog2(N_ROWS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_q, last_d;
    logic [7:0]        blen_q, blen_d;
    logic [N_ROWS-1:0] ovf_q;

    logic [CW-1:0]     cnt  [N_ROWS];
    logic [PKT_W-1:0]  head [N_ROWS];
    logic [N_ROWS-1:0] full, empty, push, pop, drop;
    logic              valid, xfer, found;
    logic [GW-1:0]     idx;
    logic [PKT_W-1:0]  data;
    logic              hdr;

    function automatic logic [7:0] burst_len(input logic [CW-1:0] c);
        if (int'(c) > MAX_BURST)
            return 8'(MAX_BURST);
        return 8'(c);
    endfunction

    for (genvar i = 0; i < N_ROWS; i++) begin : g_row
        row_pkt_fifo #(.DEPTH(FIFO_DEPTH), .W(PKT_W)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (bus.enc_data[PKT_W*i +: PKT_W]),
            .dout  (head[i]),
            .count (cnt[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    assign valid = (state_q != IDLE);
    assign xfer  = valid && bus.out_ready;

    // A full FIFO still accepts a word when the same row is being drained this cycle.
    always_comb begin
        pop  = '0;
        push = '0;
        drop = '0;
        for (int i = 0; i < N_ROWS; i++) begin
            pop[i]  = (state_q == BURST) && xfer && (grant_q == GW'(i));
            push[i] = bus.enc_ready[i] && (!full[i] || pop[i]);
            drop[i] = bus.enc_ready[i] && full[i] && !pop[i];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        blen_d  = blen_q;
        last_d  = last_q;
        found   = 1'b0;
        idx     = '0;
        case (state_q)
            IDLE: begin
                for (int k = 1; k <= N_ROWS; k++) begin
                    idx = GW'((int'(last_q) + k) % N_ROWS);
                    if (!found && !empty[idx]) begin
                        found   = 1'b1;
                        grant_d = idx;
                        blen_d  = burst_len(cnt[idx]);
                    end
                end
                if (found)
                    state_d = HDR;
            end
            HDR: begin
                if (xfer)
                    state_d = BURST;
            end
            BURST: begin
                if (xfer) begin
                    blen_d = blen_q - 8'd1;
                    if (blen_q == 8'd1) begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data = '0;
        hdr  = 1'b0;
        case (state_q)
            HDR: begin
                hdr                            = 1'b1;
                data[HDR_BLEN_MSB -: 8]        = blen_q;
                data[HDR_ROW_MSB -: 8]         = 8'(grant_q);
            end
            BURST:   data = head[grant_q];
            default: data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(N_ROWS - 1);
            blen_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            blen_q  <= blen_d;
            ovf_q   <= (ovf_q & ~{N_ROWS{bus.ovf_clear}}) | drop;
        end
    end

    assign bus.out_valid = valid;
    assign bus.out_hdr   = hdr;
    assign bus.out_data  = data;
    assign bus.ovf_flag  = ovf_q;

endmodule

// File: tb/tb_row_packet_arbiter.sv
// Bench for row_packet_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_row_packet_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 8;
    localparam int MAXB  = 4;

    typedef logic [15:0] wq_t[$];

    logic clk = 1'b0;
    logic rst;

    row_packet_arbiter_if #(.N_ROWS(N)) bus();

    row_packet_arbiter #(.N_ROWS(N), .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    wq_t          mq [N];
    int           mph;
    int           mgrant;
    int           mblen;
    int           mlast;
    logic [N-1:0] movf;
    logic [16:0]  log_q[$];
    logic         pv, pr, ph;
    logic [15:0]  pd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [15:0] model_data();
        if (mph == 1)
            return {8'(mblen), 8'(mgrant)};
        if (mph == 2 && mq[mgrant].size() > 0)
            return mq[mgrant][0];
        return 16'h0000;
    endfunction

    // Compare outputs against the model on the falling edge, then advance the model by the coming rising edge.
    task automatic tick();
        int          sz [N];
        logic        xfer;
        int          popped;
        logic [N-1:0] drops;
        logic        got;
        @(negedge clk);
        if (pv && !pr) begin
            check("stall_hold_hdr", bus.out_hdr, ph);
            check("stall_hold_data", bus.out_data, pd);
        end
        check("valid", bus.out_valid, (mph != 0));
        if (mph != 0) begin
            check("hdr", bus.out_hdr, (mph == 1));
            check("data", bus.out_data, model_data());
        end
        check("ovf", bus.ovf_flag, movf);
        pv = bus.out_valid; pr = bus.out_ready; ph = bus.out_hdr; pd = bus.out_data;

        if (rst) begin
            for (int r = 0; r < N; r++) mq[r].delete();
            mph = 0; mlast = N - 1; movf = '0; mblen = 0; mgrant = 0;
            pv = 1'b0;
        end else begin
            for (int r = 0; r < N; r++) sz[r] = mq[r].size();
            xfer = (mph != 0) && bus.out_ready;
            if (xfer) log_q.push_back({bus.out_hdr, bus.out_data});
            popped = -1;
            if (mph == 2 && xfer) begin
                void'(mq[mgrant].pop_front());
                popped = mgrant;
            end
            drops = '0;
            for (int r = 0; r < N; r++) begin
                if (bus.enc_ready[r]) begin
                    if (sz[r] < DEPTH || popped == r) mq[r].push_back(bus.enc_data[16*r +: 16]);
                    else drops[r] = 1'b1;
                end
            end
            case (mph)
                0: begin
                    got = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        int r;
                        r = (mlast + k) % N;
                        if (!got && sz[r] > 0) begin
                            got = 1'b1; mgrant = r;
                            mblen = (sz[r] > MAXB) ? MAXB : sz[r];
                            mph = 1;
                        end
                    end
                end
                1: if (xfer) mph = 2;
                default: if (xfer) begin
                    mblen--;
                    if (mblen == 0) begin mlast = mgrant; mph = 0; end
                end
            endcase
            movf = (movf & ~{N{bus.ovf_clear}}) | drops;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.enc_ready = '0;
        bus.enc_data  = '0;
    endtask

    task automatic put(input int r, input logic [15:0] w);
        bus.enc_data[16*r +: 16] = w;
        bus.enc_ready[r]         = 1'b1;
    endtask

    task automatic drain(input int n, input int budget);
        int b;
        b = budget;
        while (log_q.size() < n && b > 0) begin
            tick();
            b--;
        end
        if (log_q.size() < n) check("drain_timeout", log_q.size(), n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_log(input string name, input logic [16:0] exp[]);
        check({name, "_len"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            check(name, log_q[i], exp[i]);
    endtask

    logic [15:0] pat;
    logic [16:0] e3[], e2[], e4[], e6[];
    int          n1, n2, cur;

    initial begin
        mph = 0; mlast = N - 1; movf = '0; mblen = 0; mgrant = 0;
        pv = 1'b0; pr = 1'b0; ph = 1'b0; pd = '0;
        rst = 1'b1;
        clear_in();
        bus.out_ready = 1'b1;
        bus.ovf_clear = 1'b0;
        repeat (3) tick();
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_hdr", bus.out_hdr, 1'b0);
        check("rst_data", bus.out_data, 16'h0000);
        check("rst_ovf", bus.ovf_flag, 4'b0000);
        rst = 1'b0;
        tick();

        // single word on row 2: header two cycles after the strobe
        log_q.delete();
        put(2, 16'h1234);
        tick();
        clear_in();
        tick();
        check("t1_hdr_valid", bus.out_valid, 1'b1);
        check("t1_hdr_flag", bus.out_hdr, 1'b1);
        check("t1_hdr_word", bus.out_data, 16'h0102);
        tick();
        check("t1_data_hdr", bus.out_hdr, 1'b0);
        check("t1_data_word", bus.out_data, 16'h1234);
        tick();
        check("t1_idle", bus.out_valid, 1'b0);

        // six words on row 1 while a row-0 primer is stalled in its header
        log_q.delete();
        bus.out_ready = 1'b0;
        put(0, 16'h00AA);
        tick();
        clear_in();
        tick();
        for (int k = 0; k < 6; k++) begin
            put(1, 16'h1100 + 16'(k));
            tick();
        end
        clear_in();
        bus.out_ready = 1'b1;
        drain(10, 60);
        e3 = '{17'h10100, 17'h000AA, 17'h10401, 17'h01100, 17'h01101, 17'h01102, 17'h01103,
               17'h10201, 17'h01104, 17'h01105};
        expect_log("t3_seq", e3);

        // three rows loaded together behind a row-3 primer
        do_reset();
        log_q.delete();
        bus.out_ready = 1'b0;
        put(3, 16'h3333);
        tick();
        clear_in();
        tick();
        for (int k = 0; k < 3; k++) begin
            put(0, 16'hA000 + 16'(k));
            put(1, 16'hB000 + 16'(k));
            put(3, 16'hC000 + 16'(k));
            tick();
        end
        clear_in();
        bus.out_ready = 1'b1;
        drain(14, 80);
        e2 = '{17'h10103, 17'h03333,
               17'h10300, 17'h0A000, 17'h0A001, 17'h0A002,
               17'h10301, 17'h0B000, 17'h0B001, 17'h0B002,
               17'h10303, 17'h0C000, 17'h0C001, 17'h0C002};
        expect_log("t2_seq", e2);

        // overflow: nine strobes on row 0 with the link stalled
        do_reset();
        log_q.delete();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            put(0, (k == 1) ? 16'h8000 : 16'h0F00 + 16'(k));
            tick();
        end
        clear_in();
        check("t4_ovf_set", bus.ovf_flag, 4'b0001);
        bus.out_ready = 1'b1;
        drain(11, 80);
        repeat (4) tick();
        e4 = '{17'h10100, 17'h00F00, 17'h10400, 17'h08000, 17'h00F02, 17'h00F03, 17'h00F04,
               17'h10300, 17'h00F05, 17'h00F06, 17'h00F07};
        expect_log("t4_seq", e4);
        check("t4_ovf_kept", bus.ovf_flag, 4'b0001);
        bus.ovf_clear = 1'b1;
        tick();
        bus.ovf_clear = 1'b0;
        check("t4_ovf_clr", bus.ovf_flag, 4'b0000);

        // stall pattern on out_ready during bursts on rows 1 and 2
        log_q.delete();
        pat = 16'b1011_0011_1000_1101;
        for (int k = 0; k < 5; k++) begin
            put(1, 16'h5100 + 16'(k));
            if (k < 3) put(2, 16'h5200 + 16'(k));
            else bus.enc_ready[2] = 1'b0;
            bus.out_ready = pat[k];
            tick();
        end
        clear_in();
        for (int k = 5; k < 45; k++) begin
            bus.out_ready = pat[k % 16];
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40 && (mph != 0 || mq[1].size() != 0 || mq[2].size() != 0); k++) tick();
        n1 = 0; n2 = 0; cur = -1;
        foreach (log_q[i]) begin
            if (log_q[i][16]) cur = int'(log_q[i][7:0]);
            else if (cur == 1) begin check("t5_row1", log_q[i][15:0], 16'h5100 + 16'(n1)); n1++; end
            else begin check("t5_row2", log_q[i][15:0], 16'h5200 + 16'(n2)); n2++; end
        end
        check("t5_row1_cnt", n1, 5);
        check("t5_row2_cnt", n2, 3);

        // reset in the middle of a burst
        for (int k = 0; k < 4; k++) begin
            put(1, 16'h6100 + 16'(k));
            if (k < 2) put(3, 16'h6300 + 16'(k));
            else bus.enc_ready[3] = 1'b0;
            tick();
        end
        clear_in();
        for (int k = 0; k < 20 && mph != 2; k++) tick();
        check("t6_in_burst", bus.out_valid && !bus.out_hdr, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid_drop", bus.out_valid, 1'b0);
        log_q.delete();
        put(0, 16'h7000);
        put(3, 16'h7003);
        tick();
        clear_in();
        tick();
        check("t6_first_grant", bus.out_data, 16'h0100);
        drain(4, 30);
        repeat (6) tick();
        e6 = '{17'h10100, 17'h07000, 17'h10103, 17'h07003};
        expect_log("t6_seq", e6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/row_packet_arbiter.md
# row_packet_arbiter

Round-robin arbiter that merges the 16-bit packet streams of `N_ROWS` row encoders onto one shared output link. Each encoder emits single-cycle `data_ready` pulses and cannot be back-pressured, so every row gets a small FIFO. The arbiter drains the FIFOs in bursts, each preceded by a header word that identifies the row and the burst length. It sits between the row-encoder array and the readout serializer.

## Interface
Parameters:
- `N_ROWS`, 4: number of row encoders; 2..256.
- `FIFO_DEPTH`, 8: words per row FIFO; power of two, ≥2.
- `MAX_BURST`, 4: maximum data words per grant; 1..255.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `enc_data` input 16*N_ROWS: packet from row *i* on bits [16i+15:16i].
- `enc_ready` input N_ROWS: per-row write strobe; one cycle per word.
- `out_data` output 16: link word.
- `out_hdr` output 1: 1 = `out_data` is a header; 0 = encoder word.
- `out_valid` output 1: word present.
- `out_ready` input 1: sink accepts the word; a transfer occurs when `out_valid` and `out_ready` are both high.
- `ovf_flag` output N_ROWS: sticky per-row drop flag.
- `ovf_clear` input 1: clears all `ovf_flag` bits.

## Operation
- FIFO write:
  - When `enc_ready[i]` is high, the word is written if `count_i < FIFO_DEPTH`, or if the FIFO is full and is popped in the same cycle.
  - Otherwise the word is dropped and `ovf_flag[i]` is set.
  - If `ovf_clear` and a new drop occur in the same cycle, the set wins.
- FSM states: IDLE, HDR, BURST.
- IDLE:
  - Scan the rows starting at `last_grant+1` modulo `N_ROWS` and pick the first row with `count>0`.
  - Latch `grant`, then `blen = min(count_grant, MAX_BURST)`, using the registered count.
  - Go to HDR. If no FIFO holds data, stay in IDLE.
- HDR:
  - Drive `out_valid=1`, `out_hdr=1`, `out_data={blen[7:0], grant[7:0]}`.
  - On transfer, go to BURST.
- BURST:
  - Drive `out_valid=1`, `out_hdr=0`, `out_data` = FIFO head of `grant`.
  - Each transfer pops one word and decrements `blen`.
  - On the transfer that brings `blen` to 0, set `last_grant=grant` and go to IDLE.
- Words arriving during a burst are not added to the current burst; they wait for a later grant.
- While `out_valid=1` and `out_ready=0`, `out_data` and `out_hdr` hold stable and `out_valid` does not drop.
- Encoder words pass through unmodified; the 0x8000 wrap word and timestamp words are ordinary data.
- Reset values:
  - FIFOs empty; state IDLE.
  - `last_grant = N_ROWS-1`, so row 0 has first priority.
  - `out_valid=0`, `out_hdr=0`, `out_data=0`, `ovf_flag=0`.

## Timing
- A write at cycle t is visible in `count` at t+1.
- IDLE grants at t+1 and the header appears (`out_valid=1`) at t+2: two cycles from the strobe with an idle arbiter and `out_ready=1`.
- With `out_ready` held high:
  - A burst of *b* words takes 1+*b* transfer cycles, plus one IDLE cycle before the next header.
  - Throughput is therefore *b*/(*b*+2).
- Pop and push on the same FIFO in the same cycle are both honoured; the count is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`; `count` is log2(`FIFO_DEPTH`)+1 bits wide.
- Asserting `rst` mid-burst:
  - Next cycle: IDLE, FIFOs flushed, `out_valid=0`.
  - No partial burst is resumed.

## Structure
- Shared package `row_arb_pkg`:
  - state encoding (IDLE=0, HDR=1, BURST=2);
  - header field positions (`HDR_BLEN_MSB=15`, `HDR_ROW_MSB=7`);
  - encoder word width `PKT_W=16`.
- Sub-module `row_pkt_fifo`: synchronous FIFO (`DEPTH`, `W=16`), with `push`, `pop`, `din`, `dout` (head, combinational from registers), `count`, `full`, `empty`.
  - One instance per row, generated.
  - The drop and overflow decision stays in the top level.

## Test plan
- Single word 0x1234 on row 2 at cycle 10, `out_ready=1` -> header 0x0102 at cycle 12, then 0x1234 (`out_hdr=0`) at cycle 13, then IDLE.
- Rows 0, 1 and 3 each get 3 words at the same time, `MAX_BURST=4` -> headers 0x0300, 0x0301, 0x0303 in that order, each followed by its row's words in write order.
- Row 1 gets 6 words, `MAX_BURST=4` -> header 0x0401 with 4 words, IDLE, then header 0x0201 with 2 words.
- Row 0 gets 9 strobes with `out_ready=0` -> `ovf_flag=4'b0001` after the 9th strobe. After releasing `out_ready`, exactly the first 8 words come out. Then `ovf_clear` -> `ovf_flag=0`.
- Toggle `out_ready` randomly during a burst -> `out_data`/`out_hdr` stable while stalled, no word lost or duplicated.
- Assert `rst` mid-burst -> `out_valid=0` next cycle, all FIFOs empty, and the next grant goes to row 0.
